fifo_rd_ctrl: RTL and testbench

Read-domain controller for the asynchronous FIFO, the read-side counterpart of the write-clocked dual-port RAM.
- Owns the read pointer and drives `read_addr`/`read_enable` into the RAM.
- Brings the write pointer into the read clock domain and generates `rd_empty` and a fill level.
- Registers popped data with a valid strobe.
- Exports its Gray-coded read pointer for the write-side full logic.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/fifo_rd_ctrl.sv | 94 +++++++++
 tb/tb_fifo_rd_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared async-FIFO helpers.
// Gray/binary conversion and default widths for both FIFO domains.
package fifo_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 8;

  // Conversions work on a wide container; callers zero-extend
  // into it and truncate back. Upper zero bits do not disturb
  // either conversion, so any pointer width up to PTR_MAXW works.
  localparam int PTR_MAXW = 32;

  typedef logic [PTR_MAXW-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for Gray-coded pointers.
// Ports: clk, rst_n (async low), d (foreign domain), q (synced).
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain controller of the async FIFO.
// Ports: rd_clk/rd_rst_n; rd_en pop request; wr_gray_ptr from
// write domain; ram_data/read_addr/read_enable to the RAM;
// rd_gray_ptr to write domain; data_out/data_valid popped word;
// rd_empty, rd_level, rd_underflow status.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst_n,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   wr_gray_ptr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_enable,
  output logic [ADDR_WIDTH:0]   rd_gray_ptr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  rd_empty,
  output logic [ADDR_WIDTH:0]   rd_level,
  output logic                  rd_underflow
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wq2_gray;
  logic [PW-1:0]         rd_bin_q,  rd_bin_d;
  logic [PW-1:0]         rd_gray_q, rd_gray_d;
  logic [PW-1:0]         level_q,   level_d;
  logic [DATA_WIDTH-1:0] data_q,    data_d;
  logic                  valid_q,   valid_d;
  logic                  empty_q,   empty_d;
  logic                  under_q,   under_d;
  logic                  pop;

  sync_2ff #(
    .WIDTH(PW)
  ) u_wptr_sync (
    .clk  (rd_clk),
    .rst_n(rd_rst_n),
    .d    (wr_gray_ptr),
    .q    (wq2_gray)
  );

  // Empty and level look at the pointer as it will be after this
  // edge, so a pop of the last word flags empty on the same edge.
  always_comb begin
    pop       = rd_en && !empty_q;
    rd_bin_d  = rd_bin_q + PW'(pop);
    rd_gray_d = PW'(bin2gray(ptr_t'(rd_bin_d)));
    empty_d   = (rd_gray_d == wq2_gray);
    level_d   = PW'(gray2bin(ptr_t'(wq2_gray))) - rd_bin_d;
    data_d    = data_q;
    valid_d   = 1'b0;
    under_d   = rd_en && empty_q;
    if (pop) begin
      data_d  = ram_data;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      empty_q   <= 1'b1;
      under_q   <= 1'b0;
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      empty_q   <= empty_d;
      under_q   <= under_d;
    end
  end

  assign read_addr    = rd_bin_q[ADDR_WIDTH-1:0];
  assign read_enable  = !empty_q;
  assign rd_gray_ptr  = rd_gray_q;
  assign data_out     = data_q;
  assign data_valid   = valid_q;
  assign rd_empty     = empty_q;
  assign rd_level     = level_q;
  assign rd_underflow = under_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for the FIFO read controller.
// A behavioral write side fills a RAM model and a data queue.
module tb_fifo_rd_ctrl;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int PW = AW + 1;

  logic          rd_clk = 1'b0;
  logic          rd_rst_n;
  logic          rd_en;
  logic [PW-1:0] wr_gray_ptr;
  logic [DW-1:0] ram_data;
  logic [AW-1:0] read_addr;
  logic          read_enable;
  logic [PW-1:0] rd_gray_ptr;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          rd_empty;
  logic [PW-1:0] rd_level;
  logic          rd_underflow;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [PW-1:0] wptr;
  logic [DW-1:0] sb [$];
  int            total = 0;
  int            bad = 0;

  fifo_rd_ctrl #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .rd_clk      (rd_clk),
    .rd_rst_n    (rd_rst_n),
    .rd_en       (rd_en),
    .wr_gray_ptr (wr_gray_ptr),
    .ram_data    (ram_data),
    .read_addr   (read_addr),
    .read_enable (read_enable),
    .rd_gray_ptr (rd_gray_ptr),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .rd_empty    (rd_empty),
    .rd_level    (rd_level),
    .rd_underflow(rd_underflow)
  );

  always #5 rd_clk = ~rd_clk;

  // RAM output is meaningless while disabled; poison it.
  assign ram_data = read_enable ? mem[read_addr] : 8'hEE;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] v);
    mem[wptr[AW-1:0]] = v;
    sb.push_back(v);
    wptr = wptr + 1'b1;
    wr_gray_ptr = gray(wptr);
  endtask

  task automatic do_reset();
    rd_rst_n = 1'b0;
    rd_en = 1'b0;
    wptr = '0;
    wr_gray_ptr = '0;
    sb.delete();
    tick();
    rd_rst_n = 1'b1;
    tick();
  endtask

  // Scoreboard: every popped word must match the oldest pushed one.
  always @(posedge rd_clk) begin
    logic [DW-1:0] e;
    #1;
    if (rd_rst_n && data_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_extra got=%h req=none", data_out);
      end else begin
        e = sb.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL sb_data got=%h req=%h", data_out, e);
        end
      end
    end
  end

  task automatic test_reset();
    rd_rst_n = 1'b0;
    rd_en = 1'b0;
    wptr = '0;
    wr_gray_ptr = '0;
    repeat (2) tick();
    total++;
    if (rd_empty !== 1'b1) begin
      bad++; $display("FAIL rst_empty got=%b req=1", rd_empty);
    end
    total++;
    if (read_enable !== 1'b0) begin
      bad++; $display("FAIL rst_ren got=%b req=0", read_enable);
    end
    total++;
    if (rd_level !== '0) begin
      bad++; $display("FAIL rst_level got=%0d req=0", rd_level);
    end
    total++;
    if (rd_gray_ptr !== '0) begin
      bad++; $display("FAIL rst_gray got=%b req=0", rd_gray_ptr);
    end
    total++;
    if ({data_valid, rd_underflow, data_out} !== '0) begin
      bad++;
      $display("FAIL rst_data got=%b%b%h req=000",
               data_valid, rd_underflow, data_out);
    end
    rd_rst_n = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    total++;
    if (rd_underflow !== 1'b1) begin
      bad++; $display("FAIL uf_pulse got=%b req=1", rd_underflow);
    end
    total++;
    if (read_addr !== '0 || data_valid !== 1'b0) begin
      bad++;
      $display("FAIL uf_nomove got=%0d/%b req=0/0",
               read_addr, data_valid);
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (rd_underflow !== 1'b0) begin
      bad++; $display("FAIL uf_once got=%b req=0", rd_underflow);
    end
  endtask

  task automatic test_single();
    push_word(8'hA5);
    tick();
    tick();
    total++;
    if (rd_empty !== 1'b1) begin
      bad++; $display("FAIL vis_edge2 got=%b req=1", rd_empty);
    end
    tick();
    total++;
    if (rd_empty !== 1'b0 || rd_level !== 6'd1) begin
      bad++;
      $display("FAIL vis_edge3 got=%b/%0d req=0/1", rd_empty, rd_level);
    end
    rd_en = 1'b1;
    tick();
    total++;
    if ({data_valid, data_out, rd_empty} !== {1'b1, 8'hA5, 1'b1}) begin
      bad++;
      $display("FAIL pop_last got=%b/%h/%b req=1/a5/1",
               data_valid, data_out, rd_empty);
    end
    total++;
    if (read_addr !== 5'd1) begin
      bad++; $display("FAIL pop_addr got=%0d req=1", read_addr);
    end
    tick();
    total++;
    if ({rd_underflow, data_valid, data_out} !== {2'b10, 8'hA5}) begin
      bad++;
      $display("FAIL pop_after_last got=%b/%b/%h req=1/0/a5",
               rd_underflow, data_valid, data_out);
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_full();
    int errs;
    do_reset();
    for (int i = 0; i < 32; i++) push_word(8'(i * 7 + 3));
    repeat (3) tick();
    total++;
    if (rd_level !== 6'd32 || rd_empty !== 1'b0) begin
      bad++;
      $display("FAIL full_level got=%0d/%b req=32/0", rd_level, rd_empty);
    end
    rd_en = 1'b1;
    errs = 0;
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (data_valid !== 1'b1 || rd_level !== 6'(32 - k) ||
          read_addr !== 5'(k) || rd_underflow !== 1'b0) begin
        errs++;
        $display("FAIL full_pop%0d got=%b/%0d/%0d req=1/%0d/%0d",
                 k, data_valid, rd_level, read_addr, 32 - k, k % 32);
      end
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (rd_empty !== 1'b1) begin
      bad++; $display("FAIL full_empty got=%b req=1", rd_empty);
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (rd_gray_ptr !== 6'b110000 || sb.size() != 0) begin
      bad++;
      $display("FAIL full_gray got=%b/%0d req=110000/0",
               rd_gray_ptr, sb.size());
    end
  endtask

  task automatic test_wrap();
    int errs;
    int pushed;
    pushed = 0;
    for (int i = 0; i < 3; i++) begin
      push_word(8'($urandom)); pushed++;
    end
    repeat (3) tick();
    rd_en = 1'b1;
    errs = 0;
    while (pushed < 70) begin
      push_word(8'($urandom)); pushed++;
      tick();
      if ({data_valid, rd_empty, rd_underflow} !== 3'b100) begin
        errs++;
        $display("FAIL wrap_step%0d got=%b%b%b req=100",
                 pushed, data_valid, rd_empty, rd_underflow);
      end
    end
    total++;
    if (errs != 0) bad++;
    for (int i = 0; i < 10; i++) begin
      rd_en = !rd_empty;
      tick();
    end
    rd_en = 1'b0;
    tick();
    total++;
    if (sb.size() != 0 || rd_empty !== 1'b1 || rd_level !== '0) begin
      bad++;
      $display("FAIL wrap_drain got=%0d/%b/%0d req=0/1/0",
               sb.size(), rd_empty, rd_level);
    end
    total++;
    if (rd_gray_ptr !== gray(wptr) || read_addr !== wptr[AW-1:0]) begin
      bad++;
      $display("FAIL wrap_ptr got=%b/%0d req=%b/%0d",
               rd_gray_ptr, read_addr, gray(wptr), wptr[AW-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    int first, last, nvalid, nunder, pushed, issued;
    bit started;
    first = -1; last = -1; nvalid = 0; nunder = 0;
    pushed = 0; issued = 0; started = 0;
    for (int c = 0; c < 40; c++) begin
      if (pushed < 20) begin
        push_word(8'(8'h40 + pushed)); pushed++;
      end
      if (!started && !rd_empty) started = 1;
      rd_en = started && issued < 20;
      if (rd_en) issued++;
      tick();
      if (data_valid) begin
        if (first < 0) first = c;
        last = c;
        nvalid++;
      end
      if (rd_underflow) nunder++;
    end
    rd_en = 1'b0;
    total++;
    if (nvalid != 20 || last - first != 19) begin
      bad++;
      $display("FAIL b2b_rate got=%0d/%0d req=20/19",
               nvalid, last - first);
    end
    total++;
    if (first != 3) begin
      bad++; $display("FAIL b2b_latency got=%0d req=3", first);
    end
    total++;
    if (nunder != 0) begin
      bad++; $display("FAIL b2b_underflow got=%0d req=0", nunder);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h90 + i));
    repeat (3) tick();
    rd_en = 1'b1;
    repeat (3) tick();
    total++;
    if (rd_level !== 6'd5 || data_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_level got=%0d/%b req=5/1", rd_level, data_valid);
    end
    #1;
    rd_en = 1'b0;
    rd_rst_n = 1'b0;
    wptr = '0;
    wr_gray_ptr = '0;
    #1;
    total++;
    if (rd_empty !== 1'b1 || read_enable !== 1'b0) begin
      bad++;
      $display("FAIL mid_empty got=%b/%b req=1/0", rd_empty, read_enable);
    end
    total++;
    if (rd_level !== '0 || rd_gray_ptr !== '0 || read_addr !== '0) begin
      bad++;
      $display("FAIL mid_ptr got=%0d/%b/%0d req=0/0/0",
               rd_level, rd_gray_ptr, read_addr);
    end
    total++;
    if ({data_valid, rd_underflow, data_out} !== '0) begin
      bad++;
      $display("FAIL mid_data got=%b/%b/%h req=0/0/00",
               data_valid, rd_underflow, data_out);
    end
    sb.delete();
    tick();
    rd_rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout req=finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    test_reset();
    test_single();
    test_full();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
